cu_module: RTL and testbench

CU_MODULE -- requirements
Module: cu_module

---
 rtl/cu_pkg.sv | 56 +++++
 rtl/cu_if.sv | 28 ++
 rtl/cu_decode.sv | 44 ++++
 rtl/cu_module.sv | 103 ++++++++++
 tb/tb_cu_module.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cu_pkg.sv
// cu_pkg: shared definitions for the accumulator control unit.
//   - width parameters for the RAM word, address, ALU operand, ALU opcode, flags
//   - CPU instruction opcodes (instruction bits [15:12])
//   - ALU opcode encoding driven to the external ALU
//   - flag bit positions inside the ALU flag vector
//   - FSM state encoding and the decoded control bundle
package cu_pkg;

  localparam int datalines = 16;
  localparam int adlines   = 8;
  localparam int aluwidth  = 16;
  localparam int opsize    = 4;
  localparam int numflags  = 4;

  localparam logic [3:0] OP_HALT  = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_JMP   = 4'h8;
  localparam logic [3:0] OP_JZ    = 4'h9;
  localparam logic [3:0] OP_JC    = 4'hA;

  localparam logic [opsize-1:0] ALU_ADD = 4'd0;
  localparam logic [opsize-1:0] ALU_SUB = 4'd1;
  localparam logic [opsize-1:0] ALU_AND = 4'd2;
  localparam logic [opsize-1:0] ALU_OR  = 4'd3;
  localparam logic [opsize-1:0] ALU_XOR = 4'd4;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  // Control bundle describing what the EXEC cycle of the current instruction does.
  typedef struct packed {
    logic [opsize-1:0] aluopcode;
    logic              read;
    logic              write;
    logic              load_a;
    logic              a_from_alu;
    logic              load_flags;
    logic              branch;
    logic              halt;
  } ctrl_t;

endpackage

// File: rtl/cu_if.sv
// cu_if: bundle of the signals between the control unit and its external ALU/RAM.
//   master (control unit): drives aluopcode, aluin1, aluin2, toram, addressbus,
//                          read, write; receives aluout, flags, fromram.
//   slave  (ALU + RAM)   : the mirror image.
interface cu_if;
  import cu_pkg::*;

  logic [opsize-1:0]    aluopcode;
  logic [aluwidth-1:0]  aluin1;
  logic [aluwidth-1:0]  aluin2;
  logic [aluwidth-1:0]  aluout;
  logic [numflags-1:0]  flags;
  logic [datalines-1:0] fromram;
  logic [datalines-1:0] toram;
  logic [adlines-1:0]   addressbus;
  logic                 read;
  logic                 write;

  modport master (
    output aluopcode, aluin1, aluin2, toram, addressbus, read, write,
    input  aluout, flags, fromram
  );

  modport slave (
    input  aluopcode, aluin1, aluin2, toram, addressbus, read, write,
    output aluout, flags, fromram
  );
endinterface

// File: rtl/cu_decode.sv
// cu_decode: combinational instruction decoder.
//   op     : instruction opcode (IR[15:12])
//   zflag  : latched zero flag, cflag: latched carry flag
//   ctrl   : EXEC-cycle controls (ALU opcode, strobes, A/flag loads, branch, halt)
// Opcodes B-F decode to an all-zero bundle, i.e. a NOP.
module cu_decode
  import cu_pkg::*;
(
  input  logic [3:0] op,
  input  logic       zflag,
  input  logic       cflag,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (op)
      OP_HALT:  ctrl.halt = 1'b1;
      OP_LOAD: begin
        ctrl.read   = 1'b1;
        ctrl.load_a = 1'b1;
      end
      OP_STORE: ctrl.write = 1'b1;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        ctrl.read       = 1'b1;
        ctrl.load_a     = 1'b1;
        ctrl.a_from_alu = 1'b1;
        ctrl.load_flags = 1'b1;
        case (op)
          OP_SUB:  ctrl.aluopcode = ALU_SUB;
          OP_AND:  ctrl.aluopcode = ALU_AND;
          OP_OR:   ctrl.aluopcode = ALU_OR;
          OP_XOR:  ctrl.aluopcode = ALU_XOR;
          default: ctrl.aluopcode = ALU_ADD;
        endcase
      end
      OP_JMP:   ctrl.branch = 1'b1;
      OP_JZ:    ctrl.branch = zflag;
      OP_JC:    ctrl.branch = cflag;
      default:  ;
    endcase
  end

endmodule

// File: rtl/cu_module.sv
// cu_module: two-cycle (FETCH, EXEC) accumulator control unit driving an
// external ALU and a level-sensitive RAM.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset (PC=1, IR=A=flags=0, FETCH)
//   enable : when low every register holds and read/write are forced low
//   bus    : cu_if master port (ALU operands/opcode/result, RAM address/data/strobes)
module cu_module
  import cu_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  cu_if.master bus
);

  logic [adlines-1:0]   pc;
  logic [datalines-1:0] ir;
  logic [aluwidth-1:0]  a;
  logic [numflags-1:0]  flagreg;
  state_t               state;
  state_t               next_state;
  ctrl_t                ctrl;
  logic [3:0]           op;
  logic [adlines-1:0]   addr;
  logic                 unused_bits;

  assign op   = ir[15:12];
  assign addr = ir[7:0];

  // IR[11:8] and the N/V flags are kept in the registers but never steer anything.
  assign unused_bits = ^{ir[11:8], flagreg[FLAG_N], flagreg[FLAG_V]};

  cu_decode u_decode (
    .op    (op),
    .zflag (flagreg[FLAG_Z]),
    .cflag (flagreg[FLAG_C]),
    .ctrl  (ctrl)
  );

  assign bus.aluin1 = a;
  assign bus.aluin2 = bus.fromram;
  assign bus.toram  = a;

  // Outputs are gated by rst_n as well as enable so that asserting reset kills
  // an in-flight STORE write pulse immediately, without waiting for a clock.
  always_comb begin
    next_state     = state;
    bus.addressbus = '0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.aluopcode  = '0;
    if (rst_n && enable) begin
      case (state)
        S_FETCH: begin
          bus.addressbus = pc;
          bus.read       = 1'b1;
          next_state     = S_EXEC;
        end
        S_EXEC: begin
          if (ctrl.read || ctrl.write) begin
            bus.addressbus = addr;
          end
          bus.read      = ctrl.read;
          bus.write     = ctrl.write;
          bus.aluopcode = ctrl.aluopcode;
          next_state    = ctrl.halt ? S_HALT : S_FETCH;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= 8'd1;
      ir      <= '0;
      a       <= '0;
      flagreg <= '0;
      state   <= S_FETCH;
    end else if (enable) begin
      state <= next_state;
      case (state)
        S_FETCH: begin
          ir <= bus.fromram;
          pc <= pc + 8'd1;
        end
        S_EXEC: begin
          if (ctrl.load_a) begin
            a <= ctrl.a_from_alu ? bus.aluout : bus.fromram;
          end
          if (ctrl.load_flags) begin
            flagreg <= bus.flags;
          end
          if (ctrl.branch) begin
            pc <= addr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cu_module.sv
// tb_cu_module: directed self-checking bench for cu_module.
// Provides a behavioural ALU and RAM on the slave side of cu_if. RAM writes land
// on the falling clock edge while write is high; the bench preloads programs
// through the same process while the DUT is held in reset.
module tb_cu_module;
  import cu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic enable;

  always #5 clk = ~clk;

  cu_if bus ();

  cu_module dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .bus    (bus)
  );

  logic [15:0] mem [0:255];
  logic        loadEn;
  logic        clearEn;
  logic [7:0]  loadAddr;
  logic [15:0] loadData;
  int          errors = 0;
  int          checks = 0;

  // RAM model: bench preload/clear, otherwise DUT stores.
  always @(negedge clk) begin
    if (clearEn) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (loadEn) begin
      mem[loadAddr] <= loadData;
    end else if (bus.write) begin
      mem[bus.addressbus] <= bus.toram;
    end
  end

  assign bus.fromram = mem[bus.addressbus];

  // ALU model: flags are {V, N, C, Z}; C is carry for ADD and borrow for SUB.
  logic [16:0] wide;
  logic [15:0] res;
  logic        cf;
  logic        vf;

  always_comb begin
    wide = '0;
    res  = '0;
    cf   = 1'b0;
    vf   = 1'b0;
    case (bus.aluopcode)
      ALU_ADD: begin
        wide = {1'b0, bus.aluin1} + {1'b0, bus.aluin2};
        res  = wide[15:0];
        cf   = wide[16];
        vf   = (bus.aluin1[15] == bus.aluin2[15]) && (res[15] != bus.aluin1[15]);
      end
      ALU_SUB: begin
        wide = {1'b0, bus.aluin1} - {1'b0, bus.aluin2};
        res  = wide[15:0];
        cf   = wide[16];
        vf   = (bus.aluin1[15] != bus.aluin2[15]) && (res[15] != bus.aluin1[15]);
      end
      ALU_AND: res = bus.aluin1 & bus.aluin2;
      ALU_OR:  res = bus.aluin1 | bus.aluin2;
      ALU_XOR: res = bus.aluin1 ^ bus.aluin2;
      default: ;
    endcase
    bus.aluout = res;
    bus.flags  = {vf, res[15], cf, (res == 16'h0000)};
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input int cycles);
    enable = en;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic writeWord(input logic [7:0] adr, input logic [15:0] data);
    loadAddr = adr;
    loadData = data;
    loadEn   = 1'b1;
    @(negedge clk);
    #1;
    loadEn = 1'b0;
  endtask

  task automatic clearRam();
    clearEn = 1'b1;
    @(negedge clk);
    #1;
    clearEn = 1'b0;
  endtask

  task automatic releaseReset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic loadProgram1();
    clearRam();
    writeWord(8'h10, 16'h0005);
    writeWord(8'h11, 16'h0002);
    writeWord(8'h01, 16'h1010);
    writeWord(8'h02, 16'h3011);
    writeWord(8'h03, 16'h2012);
    writeWord(8'h04, 16'h0000);
  endtask

  initial begin
    loadEn   = 1'b0;
    clearEn  = 1'b0;
    loadAddr = '0;
    loadData = '0;
    enable   = 1'b1;
    rst_n    = 1'b0;
    #12;

    // ---- Reset values (enable high, reset low) and program 1 ----
    $display("[TB] reset state and LOAD/ADD/STORE/HALT program");
    checkOutput("rst_pc", 32'(dut.pc), 32'h01);
    checkOutput("rst_ir", 32'(dut.ir), 32'h0);
    checkOutput("rst_a", 32'(dut.a), 32'h0);
    checkOutput("rst_flags", 32'(dut.flagreg), 32'h0);
    checkOutput("rst_state", 32'(dut.state), 32'(S_FETCH));
    checkOutput("rst_addr", 32'(bus.addressbus), 32'h0);
    checkOutput("rst_read", 32'(bus.read), 32'h0);
    checkOutput("rst_write", 32'(bus.write), 32'h0);
    checkOutput("rst_aluop", 32'(bus.aluopcode), 32'h0);
    loadProgram1();
    releaseReset();
    checkOutput("p1_fetch_addr", 32'(bus.addressbus), 32'h01);
    checkOutput("p1_fetch_read", 32'(bus.read), 32'h1);
    applyStimulus(1'b1, 1);
    checkOutput("p1_load_addr", 32'(bus.addressbus), 32'h10);
    applyStimulus(1'b1, 1);
    checkOutput("p1_a_load", 32'(dut.a), 32'h0005);
    applyStimulus(1'b1, 1);
    checkOutput("p1_add_addr", 32'(bus.addressbus), 32'h11);
    checkOutput("p1_add_read", 32'(bus.read), 32'h1);
    applyStimulus(1'b1, 1);
    checkOutput("p1_a_add", 32'(dut.a), 32'h0007);
    applyStimulus(1'b1, 1);
    checkOutput("p1_st_write", 32'(bus.write), 32'h1);
    checkOutput("p1_st_read", 32'(bus.read), 32'h0);
    checkOutput("p1_st_addr", 32'(bus.addressbus), 32'h12);
    checkOutput("p1_st_data", 32'(bus.toram), 32'h0007);
    applyStimulus(1'b1, 3);
    checkOutput("p1_mem18", 32'(mem[8'h12]), 32'h0007);
    checkOutput("p1_halt_state", 32'(dut.state), 32'(S_HALT));
    checkOutput("p1_halt_read", 32'(bus.read), 32'h0);
    checkOutput("p1_halt_write", 32'(bus.write), 32'h0);
    checkOutput("p1_halt_pc", 32'(dut.pc), 32'h05);
    applyStimulus(1'b1, 2);
    checkOutput("p1_halt_stays", 32'(dut.state), 32'(S_HALT));

    // ---- SUB to zero, JZ taken, JZ not taken, JC taken ----
    $display("[TB] SUB/JZ/JC program");
    rst_n = 1'b0;
    clearRam();
    writeWord(8'h01, 16'h1030);
    writeWord(8'h02, 16'h4031);
    writeWord(8'h03, 16'h9020);
    writeWord(8'h20, 16'h3033);
    writeWord(8'h21, 16'h9040);
    writeWord(8'h22, 16'h4034);
    writeWord(8'h23, 16'hA050);
    writeWord(8'h30, 16'h0003);
    writeWord(8'h31, 16'h0003);
    writeWord(8'h33, 16'h0001);
    writeWord(8'h34, 16'h0002);
    releaseReset();
    applyStimulus(1'b1, 3);
    checkOutput("p2_sub_aluop", 32'(bus.aluopcode), 32'(ALU_SUB));
    applyStimulus(1'b1, 1);
    checkOutput("p2_sub_a", 32'(dut.a), 32'h0000);
    checkOutput("p2_sub_flags", 32'(dut.flagreg), 32'h1);
    applyStimulus(1'b1, 2);
    checkOutput("p2_jz_taken_pc", 32'(dut.pc), 32'h20);
    applyStimulus(1'b1, 2);
    checkOutput("p2_add_flags", 32'(dut.flagreg), 32'h0);
    applyStimulus(1'b1, 1);
    checkOutput("p2_jz_noread", 32'(bus.read), 32'h0);
    applyStimulus(1'b1, 1);
    checkOutput("p2_jz_fall_pc", 32'(dut.pc), 32'h22);
    applyStimulus(1'b1, 2);
    checkOutput("p2_borrow_a", 32'(dut.a), 32'hFFFF);
    checkOutput("p2_borrow_flags", 32'(dut.flagreg), 32'h6);
    applyStimulus(1'b1, 2);
    checkOutput("p2_jc_taken_pc", 32'(dut.pc), 32'h50);

    // ---- Enable low for 5 cycles in the middle of program 1 ----
    $display("[TB] enable stall");
    rst_n = 1'b0;
    loadProgram1();
    releaseReset();
    applyStimulus(1'b1, 3);
    enable = 1'b0;
    #1;
    checkOutput("en_read_low", 32'(bus.read), 32'h0);
    applyStimulus(1'b0, 5);
    checkOutput("en_pc_hold", 32'(dut.pc), 32'h03);
    checkOutput("en_a_hold", 32'(dut.a), 32'h0005);
    checkOutput("en_state_hold", 32'(dut.state), 32'(S_EXEC));
    applyStimulus(1'b1, 5);
    checkOutput("en_mem18", 32'(mem[8'h12]), 32'h0007);
    checkOutput("en_state_halt", 32'(dut.state), 32'(S_HALT));
    checkOutput("en_pc_final", 32'(dut.pc), 32'h05);

    // ---- Reset asserted during the STORE EXEC cycle ----
    $display("[TB] reset during STORE");
    rst_n = 1'b0;
    loadProgram1();
    releaseReset();
    applyStimulus(1'b1, 5);
    checkOutput("rs_write_before", 32'(bus.write), 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("rs_write_drop", 32'(bus.write), 32'h0);
    checkOutput("rs_pc", 32'(dut.pc), 32'h01);
    checkOutput("rs_a", 32'(dut.a), 32'h0);
    @(negedge clk);
    #1;
    checkOutput("rs_no_store", 32'(mem[8'h12]), 32'h0);
    releaseReset();
    checkOutput("rs_pc_after", 32'(dut.pc), 32'h01);
    checkOutput("rs_a_after", 32'(dut.a), 32'h0);
    checkOutput("rs_fetch_addr", 32'(bus.addressbus), 32'h01);

    // ---- JMP 0xFF, PC wrap, NOP only moves PC ----
    $display("[TB] JMP wrap and NOP");
    rst_n = 1'b0;
    clearRam();
    writeWord(8'h01, 16'h1040);
    writeWord(8'h02, 16'h80FF);
    writeWord(8'h40, 16'h1234);
    writeWord(8'hFF, 16'hB7AB);
    releaseReset();
    applyStimulus(1'b1, 3);
    checkOutput("jw_jmp_read", 32'(bus.read), 32'h0);
    checkOutput("jw_jmp_write", 32'(bus.write), 32'h0);
    applyStimulus(1'b1, 1);
    checkOutput("jw_pc_ff", 32'(dut.pc), 32'hFF);
    applyStimulus(1'b1, 1);
    checkOutput("jw_pc_wrap", 32'(dut.pc), 32'h00);
    checkOutput("jw_ir_nop", 32'(dut.ir), 32'hB7AB);
    applyStimulus(1'b1, 1);
    checkOutput("jw_nop_pc", 32'(dut.pc), 32'h00);
    checkOutput("jw_nop_a", 32'(dut.a), 32'h1234);
    checkOutput("jw_nop_flags", 32'(dut.flagreg), 32'h0);
    checkOutput("jw_nop_state", 32'(dut.state), 32'(S_FETCH));
    applyStimulus(1'b1, 2);
    checkOutput("jw_halt_at0", 32'(dut.state), 32'(S_HALT));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
